// File: rtl/counter_ctrl_pkg.sv
// Shared definitions for the cascaded mode counter and its sequencer.
// Holds the counter MODO encodings, the sequencer state encoding and
// the default data and step-count widths.
package counter_ctrl_pkg;

  localparam int unsigned DefWidth = 16;
  localparam int unsigned DefStepW = 8;

  localparam logic [1:0] MODO_UP    = 2'b00;
  localparam logic [1:0] MODO_DOWN  = 2'b01;
  localparam logic [1:0] MODO_DOWN3 = 2'b10;
  localparam logic [1:0] MODO_LOAD  = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StRun,
    StFin
  } state_e;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command handshake, counter drive/observe bus and completion status
// between the requester, the sequencer and the counter.
//   cmd_*        : command fields and valid/ready handshake
//   enb/modo/d   : counter controls driven by the sequencer
//   q/rco        : counter outputs observed by the sequencer
//   busy/done/result/rco_hit : sequencer status
// modport slave is the sequencer's view; modport master is the environment's view.
interface counter_sequencer_if #(
  parameter int unsigned WIDTH  = counter_ctrl_pkg::DefWidth,
  parameter int unsigned STEP_W = counter_ctrl_pkg::DefStepW
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_modo;
  logic [WIDTH-1:0]  cmd_start;
  logic [STEP_W-1:0] cmd_steps;
  logic              cmd_stop_rco;
  logic              enb;
  logic [1:0]        modo;
  logic [WIDTH-1:0]  d;
  logic [WIDTH-1:0]  q;
  logic              rco;
  logic              busy;
  logic              done;
  logic [WIDTH-1:0]  result;
  logic              rco_hit;

  modport slave (
    input  cmd_valid, cmd_modo, cmd_start, cmd_steps, cmd_stop_rco, q, rco,
    output cmd_ready, enb, modo, d, busy, done, result, rco_hit
  );

  modport master (
    output cmd_valid, cmd_modo, cmd_start, cmd_steps, cmd_stop_rco, q, rco,
    input  cmd_ready, enb, modo, d, busy, done, result, rco_hit
  );
endinterface

// File: rtl/steps_down_counter.sv
// Loadable down counter tracking remaining RUN steps.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load/i_value : load remaining count (has priority over i_dec)
//   i_dec          : decrement by one; saturates at zero
//   o_last         : remaining count equals one
module steps_down_counter #(
  parameter int unsigned STEP_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [STEP_W-1:0] i_value,
  input  logic              i_dec,
  output logic              o_last
);

  logic [STEP_W-1:0] r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - {{(STEP_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_last = (r_count == {{(STEP_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/counter_sequencer.sv
// Sequences the cascaded mode counter: parallel load of a start value, then
// N counting clocks in the requested mode, optional early stop on RCO, and
// capture of the final count.
//   i_clk, i_rst_n : clock, async active-low reset
//   bus (slave)    : command handshake, counter controls, status
module counter_sequencer
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned STEP_W = DefStepW
) (
  input logic                 i_clk,
  input logic                 i_rst_n,
  counter_sequencer_if.slave  bus
);

  state_e            r_state;
  logic              r_enb;
  logic [1:0]        r_modo;
  logic [WIDTH-1:0]  r_d;
  logic              r_done;
  logic [WIDTH-1:0]  r_result;
  logic              r_rco_hit;
  logic [1:0]        r_mode;
  logic [STEP_W-1:0] r_steps;
  logic              r_stop_rco;

  logic w_accept;
  logic w_last;

  assign w_accept = bus.cmd_valid && (r_state == StIdle);

  // Remaining-steps counter is loaded on the LOAD->RUN edge and ticks on every RUN edge.
  steps_down_counter #(
    .STEP_W (STEP_W)
  ) u_steps (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (r_state == StLoad),
    .i_value (r_steps),
    .i_dec   (r_state == StRun),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_enb      <= 1'b0;
      r_modo     <= MODO_UP;
      r_d        <= '0;
      r_done     <= 1'b0;
      r_result   <= '0;
      r_rco_hit  <= 1'b0;
      r_mode     <= MODO_UP;
      r_steps    <= '0;
      r_stop_rco <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_mode     <= bus.cmd_modo;
            r_steps    <= bus.cmd_steps;
            r_stop_rco <= bus.cmd_stop_rco;
            r_rco_hit  <= 1'b0;
            r_enb      <= 1'b1;
            r_modo     <= MODO_LOAD;
            r_d        <= bus.cmd_start;
            r_state    <= StLoad;
          end
        end
        StLoad: begin
          r_d <= '0;
          if ((r_steps != '0) && (r_mode != MODO_LOAD)) begin
            r_modo  <= r_mode;
            r_state <= StRun;
          end else begin
            r_enb   <= 1'b0;
            r_modo  <= MODO_UP;
            r_state <= StFin;
          end
        end
        StRun: begin
          if (bus.rco) begin
            r_rco_hit <= 1'b1;
          end
          // This edge still counts, so an RCO abort lands one step past the wrap.
          if (w_last || (r_stop_rco && bus.rco)) begin
            r_enb   <= 1'b0;
            r_modo  <= MODO_UP;
            r_state <= StFin;
          end
        end
        StFin: begin
          r_result <= bus.q;
          r_done   <= 1'b1;
          r_state  <= StIdle;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.cmd_ready = (r_state == StIdle);
  assign bus.busy      = (r_state != StIdle);
  assign bus.enb       = r_enb;
  assign bus.modo      = r_modo;
  assign bus.d         = r_d;
  assign bus.done      = r_done;
  assign bus.result    = r_result;
  assign bus.rco_hit   = r_rco_hit;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural model of the
// 16-bit mode counter (RCO registered on the wrapping count edge).
module tb_counter_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  counter_sequencer_if #(.WIDTH(16), .STEP_W(8)) bus ();

  counter_sequencer #(.WIDTH(16), .STEP_W(8)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // Counter model: no reset, RCO goes high on the edge that wraps.
  logic [15:0] cnt_q = 16'h0000;
  logic        cnt_rco = 1'b0;
  assign bus.q   = cnt_q;
  assign bus.rco = cnt_rco;

  always @(posedge clk) begin
    if (bus.enb) begin
      case (bus.modo)
        2'b00: begin cnt_q <= cnt_q + 16'd1; cnt_rco <= (cnt_q == 16'hFFFF); end
        2'b01: begin cnt_q <= cnt_q - 16'd1; cnt_rco <= (cnt_q == 16'h0000); end
        2'b10: begin cnt_q <= cnt_q - 16'd3; cnt_rco <= (cnt_q < 16'd3); end
        default: begin cnt_q <= bus.d; cnt_rco <= 1'b0; end
      endcase
    end else begin
      cnt_rco <= 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a command while idle; returns just after the accepting edge.
  task automatic issue(input logic [1:0] mode, input logic [15:0] start,
                       input logic [7:0] steps, input logic stop);
    bus.cmd_modo     = mode;
    bus.cmd_start    = start;
    bus.cmd_steps    = steps;
    bus.cmd_stop_rco = stop;
    bus.cmd_valid    = 1'b1;
    tick();
    bus.cmd_valid    = 1'b0;
  endtask

  // Edges from the accept edge until DONE is seen; -1 if it never shows.
  task automatic wait_done(output int edges);
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (bus.done === 1'b1) begin
        edges = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.cmd_valid = 1'b0;
    bus.cmd_modo = 2'b00;
    bus.cmd_start = 16'h0000;
    bus.cmd_steps = 8'd0;
    bus.cmd_stop_rco = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (bus.enb !== 1'b0) begin failures++; $display("FAIL reset_enb got %b want 0", bus.enb); end
    checks++; if (bus.modo !== 2'b00) begin failures++; $display("FAIL reset_modo got %b want 00", bus.modo); end
    checks++; if (bus.d !== 16'h0000) begin failures++; $display("FAIL reset_d got %h want 0000", bus.d); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got %b want 0", bus.done); end
    checks++; if (bus.result !== 16'h0000) begin failures++; $display("FAIL reset_result got %h want 0000", bus.result); end
    checks++; if (bus.rco_hit !== 1'b0) begin failures++; $display("FAIL reset_rco_hit got %b want 0", bus.rco_hit); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got %b want 1", bus.cmd_ready); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_up_count();
    int edges;
    issue(2'b00, 16'h0000, 8'd5, 1'b0);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL up_busy got %b want 1", bus.busy); end
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL up_ready got %b want 0", bus.cmd_ready); end
    checks++; if ({bus.enb, bus.modo} !== 3'b111) begin failures++; $display("FAIL up_load_ctl got %b want 111", {bus.enb, bus.modo}); end
    checks++; if (bus.d !== 16'h0000) begin failures++; $display("FAIL up_load_d got %h want 0000", bus.d); end
    tick();
    checks++; if ({bus.enb, bus.modo, bus.d} !== {1'b1, 2'b00, 16'h0000}) begin failures++; $display("FAIL up_run_ctl got %b/%b/%h want 1/00/0000", bus.enb, bus.modo, bus.d); end
    wait_done(edges);
    checks++; if (edges !== 6) begin failures++; $display("FAIL up_latency got %0d want 7", edges + 1); end
    checks++; if (bus.result !== 16'h0005) begin failures++; $display("FAIL up_result got %h want 0005", bus.result); end
    checks++; if (bus.rco_hit !== 1'b0) begin failures++; $display("FAIL up_rco_hit got %b want 0", bus.rco_hit); end
    tick();
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL up_done_pulse got %b want 0", bus.done); end
    checks++; if (bus.result !== 16'h0005) begin failures++; $display("FAIL up_result_hold got %h want 0005", bus.result); end
  endtask

  task automatic test_down_wrap();
    int edges;
    issue(2'b01, 16'h0001, 8'd3, 1'b0);
    wait_done(edges);
    checks++; if (edges !== 5) begin failures++; $display("FAIL down_latency got %0d want 5", edges); end
    checks++; if (bus.result !== 16'hFFFE) begin failures++; $display("FAIL down_result got %h want FFFE", bus.result); end
    checks++; if (bus.rco_hit !== 1'b1) begin failures++; $display("FAIL down_rco_hit got %b want 1", bus.rco_hit); end
    tick();
  endtask

  // FFFE loads at E1, FFFF at E2, wrap to 0000 with RCO at E3, abort at E4 (Q=0001), DONE at E5.
  task automatic test_rco_abort();
    issue(2'b00, 16'hFFFE, 8'd10, 1'b1);
    tick();
    tick();
    tick();
    checks++; if (bus.enb !== 1'b1) begin failures++; $display("FAIL abort_enb_e3 got %b want 1", bus.enb); end
    tick();
    checks++; if (bus.enb !== 1'b0) begin failures++; $display("FAIL abort_enb_e4 got %b want 0", bus.enb); end
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL abort_busy_fin got %b want 1", bus.busy); end
    tick();
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL abort_done_e5 got %b want 1", bus.done); end
    checks++; if (bus.result !== 16'h0001) begin failures++; $display("FAIL abort_result got %h want 0001", bus.result); end
    checks++; if (bus.rco_hit !== 1'b1) begin failures++; $display("FAIL abort_rco_hit got %b want 1", bus.rco_hit); end
    tick();
  endtask

  task automatic test_back_to_back();
    int edges;
    issue(2'b11, 16'hA5A5, 8'd7, 1'b0);
    // Second command held while busy.
    bus.cmd_modo = 2'b00;
    bus.cmd_start = 16'h0010;
    bus.cmd_steps = 8'd2;
    bus.cmd_stop_rco = 1'b0;
    bus.cmd_valid = 1'b1;
    tick();
    checks++; if (bus.cmd_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_busy got %b want 0", bus.cmd_ready); end
    tick();
    checks++; if (bus.done !== 1'b1) begin failures++; $display("FAIL b2b_load_done got %b want 1", bus.done); end
    checks++; if (bus.result !== 16'hA5A5) begin failures++; $display("FAIL b2b_load_result got %h want A5A5", bus.result); end
    checks++; if (bus.rco_hit !== 1'b0) begin failures++; $display("FAIL b2b_rco_hit_clr got %b want 0", bus.rco_hit); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready_done got %b want 1", bus.cmd_ready); end
    tick();
    bus.cmd_valid = 1'b0;
    checks++; if ({bus.busy, bus.modo, bus.d} !== {1'b1, 2'b11, 16'h0010}) begin failures++; $display("FAIL b2b_accept got %b/%b/%h want 1/11/0010", bus.busy, bus.modo, bus.d); end
    wait_done(edges);
    checks++; if (edges !== 4) begin failures++; $display("FAIL b2b_latency got %0d want 4", edges); end
    checks++; if (bus.result !== 16'h0012) begin failures++; $display("FAIL b2b_result got %h want 0012", bus.result); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int edges;
    int done_seen;
    issue(2'b10, 16'h0030, 8'd8, 1'b0);
    tick();
    tick();
    tick();
    checks++; if ({bus.enb, bus.modo} !== 3'b110) begin failures++; $display("FAIL rst_run_ctl got %b want 110", {bus.enb, bus.modo}); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.enb, bus.modo} !== 3'b000) begin failures++; $display("FAIL rst_async_ctl got %b want 000", {bus.enb, bus.modo}); end
    checks++; if (bus.cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_async_ready got %b want 1", bus.cmd_ready); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got %b want 0", bus.busy); end
    done_seen = 0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      if (bus.done === 1'b1) done_seen++;
      tick();
    end
    checks++; if (done_seen !== 0) begin failures++; $display("FAIL rst_no_done got %0d want 0", done_seen); end
    issue(2'b10, 16'h0009, 8'd3, 1'b0);
    wait_done(edges);
    checks++; if (edges !== 5) begin failures++; $display("FAIL rst_next_latency got %0d want 5", edges); end
    checks++; if (bus.result !== 16'h0000) begin failures++; $display("FAIL rst_next_result got %h want 0000", bus.result); end
    checks++; if (bus.rco_hit !== 1'b0) begin failures++; $display("FAIL rst_next_rco_hit got %b want 0", bus.rco_hit); end
    tick();
  endtask

  initial begin
    test_reset();
    test_up_count();
    test_down_wrap();
    test_rco_abort();
    test_back_to_back();
    test_reset_mid_run();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
